// File: rtl/lvds_tx_serializer.sv
// LVDS TX serializer: pulls 32-bit I/Q words from the TX FIFO, inserts sync bits
// and shifts each frame out MSB-first, two bits per DDR clock (16 clocks per frame).
module lvds_tx_serializer #(
    parameter logic [1:0] I_SYNC = 2'b10,
    parameter logic [1:0] Q_SYNC = 2'b01
) (
    input  logic        i_ddr_clk,
    input  logic        i_reset,
    input  logic        i_tx_en,
    input  logic        i_fifo_empty,
    output logic        o_fifo_pull,
    input  logic [31:0] i_fifo_data,
    output logic        o_tx_bit_rise,
    output logic        o_tx_bit_fall,
    output logic        o_frame_start,
    output logic        o_busy,
    input  logic        i_clear_underrun,
    output logic        o_underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PULL = 2'd1,
        LOAD = 2'd2,
        TX   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  phase;
    logic [31:0] shreg;
    logic        next_valid;
    logic        fifo_pull_q;
    logic        underrun_q;

    logic        data_ready;
    logic        pull_decide;
    logic        frame_end;
    logic [31:0] data_frame;
    logic        unused_sync_bits;

    assign data_ready  = i_tx_en & ~i_fifo_empty;
    assign pull_decide = (state == TX) && (phase == 4'd12);
    assign frame_end   = (state == TX) && (phase == 4'd15);
    assign data_frame  = {I_SYNC, i_fifo_data[29:16], Q_SYNC, i_fifo_data[13:0]};

    // The sync positions of the FIFO word are overwritten by the inserted sync patterns.
    assign unused_sync_bits = ^{i_fifo_data[31:30], i_fifo_data[15:14]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_ddr_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (data_ready) state_next = PULL;
            PULL:    state_next = LOAD;
            LOAD:    state_next = TX;
            TX:      if (frame_end && !next_valid && !i_tx_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift register, phase counter, pull strobe and look-ahead flag.
    always_ff @(posedge i_ddr_clk or posedge i_reset) begin
        if (i_reset) begin
            shreg       <= 32'h0;
            phase       <= 4'd0;
            next_valid  <= 1'b0;
            fifo_pull_q <= 1'b0;
        end else begin
            fifo_pull_q <= data_ready && ((state == IDLE) || pull_decide);

            if (pull_decide) begin
                next_valid <= data_ready;
            end else if (frame_end) begin
                next_valid <= 1'b0;
            end

            case (state)
                LOAD: begin
                    shreg <= data_frame;
                    phase <= 4'd0;
                end
                TX: begin
                    if (phase == 4'd15) begin
                        // Gapless reload; an empty slot becomes the sync-less idle frame.
                        shreg <= next_valid ? data_frame : 32'h0;
                        phase <= 4'd0;
                    end else begin
                        shreg <= {shreg[29:0], 2'b00};
                        phase <= phase + 4'd1;
                    end
                end
                default: begin
                    shreg <= 32'h0;
                    phase <= 4'd0;
                end
            endcase
        end
    end

    // Set wins over clear; only an idle frame sent while still enabled is an underrun.
    always_ff @(posedge i_ddr_clk or posedge i_reset) begin
        if (i_reset) begin
            underrun_q <= 1'b0;
        end else if (frame_end && !next_valid && i_tx_en) begin
            underrun_q <= 1'b1;
        end else if (i_clear_underrun) begin
            underrun_q <= 1'b0;
        end
    end

    always_comb begin
        o_tx_bit_rise = 1'b0;
        o_tx_bit_fall = 1'b0;
        o_frame_start = 1'b0;
        o_busy        = (state != IDLE);
        if (state == TX) begin
            o_tx_bit_rise = shreg[31];
            o_tx_bit_fall = shreg[30];
            o_frame_start = (phase == 4'd0);
        end
    end

    assign o_fifo_pull = fifo_pull_q;
    assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Directed self-checking bench for lvds_tx_serializer with a behavioural TX FIFO.
module tb_lvds_tx_serializer;

    logic        i_ddr_clk;
    logic        i_reset;
    logic        i_tx_en;
    logic        i_fifo_empty;
    logic        o_fifo_pull;
    logic [31:0] i_fifo_data;
    logic        o_tx_bit_rise;
    logic        o_tx_bit_fall;
    logic        o_frame_start;
    logic        o_busy;
    logic        i_clear_underrun;
    logic        o_underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fifo_q[$];
    logic [1:0]  rec_pair [0:255];
    logic        rec_pull [0:255];
    logic        rec_fs   [0:255];
    logic        rec_busy [0:255];
    logic        rec_ur   [0:255];
    int          rec_n;

    lvds_tx_serializer dut (
        .i_ddr_clk        (i_ddr_clk),
        .i_reset          (i_reset),
        .i_tx_en          (i_tx_en),
        .i_fifo_empty     (i_fifo_empty),
        .o_fifo_pull      (o_fifo_pull),
        .i_fifo_data      (i_fifo_data),
        .o_tx_bit_rise    (o_tx_bit_rise),
        .o_tx_bit_fall    (o_tx_bit_fall),
        .o_frame_start    (o_frame_start),
        .o_busy           (o_busy),
        .i_clear_underrun (i_clear_underrun),
        .o_underrun       (o_underrun)
    );

    initial begin
        i_ddr_clk = 1'b0;
        forever #5 i_ddr_clk = ~i_ddr_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; the FIFO pops on the edge that closes a pull cycle.
    task automatic tick();
        logic pulled;
        pulled = o_fifo_pull;
        @(posedge i_ddr_clk);
        #1;
        if (pulled) begin
            n_tests++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL pull_on_empty: o_fifo_pull=1 required 0 (FIFO empty)");
            end else begin
                i_fifo_data = fifo_q.pop_front();
            end
        end
        i_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        i_fifo_empty = 1'b0;
    endtask

    task automatic step();
        if (rec_n < 256) begin
            rec_pair[rec_n] = {o_tx_bit_rise, o_tx_bit_fall};
            rec_pull[rec_n] = o_fifo_pull;
            rec_fs[rec_n]   = o_frame_start;
            rec_busy[rec_n] = o_busy;
            rec_ur[rec_n]   = o_underrun;
            rec_n++;
        end
        tick();
    endtask

    function automatic logic [31:0] rec_word(input int base);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 16; i++) w = {w[29:0], rec_pair[base + i]};
        return w;
    endfunction

    function automatic int count_pulls(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (rec_pull[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic do_reset();
        i_reset          = 1'b1;
        i_tx_en          = 1'b0;
        i_clear_underrun = 1'b0;
        fifo_q.delete();
        i_fifo_empty     = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    // Raise enable with data queued and advance to phase 0 of the first frame.
    task automatic start_stream();
        i_tx_en = 1'b1;
        tick();
        tick();
        tick();
        rec_n = 0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_tx_en = 1'b1;
        push(32'h1555_2AAA);
        tick();
        n_tests++;
        if ({o_fifo_pull, o_tx_bit_rise, o_tx_bit_fall, o_frame_start, o_busy, o_underrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {o_fifo_pull, o_tx_bit_rise, o_tx_bit_fall, o_frame_start, o_busy, o_underrun});
        end
        tick();
        n_tests++;
        if ({o_fifo_pull, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held: pull/busy got %b required 00", {o_fifo_pull, o_busy});
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] w;
        int fs_cnt;
        do_reset();
        push(32'h1555_2AAA);
        i_tx_en = 1'b1;
        n_tests++;
        if ({o_fifo_pull, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_pre_en: pull/busy got %b required 00", {o_fifo_pull, o_busy});
        end
        tick();
        n_tests++;
        if ({o_fifo_pull, o_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_pull: pull/busy got %b required 11", {o_fifo_pull, o_busy});
        end
        tick();
        n_tests++;
        if ({o_fifo_pull, o_frame_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_load: pull/frame_start got %b required 00", {o_fifo_pull, o_frame_start});
        end
        tick();
        rec_n = 0;
        for (int i = 0; i < 17; i++) begin
            if (i == 10) i_tx_en = 1'b0;
            step();
        end
        n_tests++;
        if (rec_pair[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL single_first_pair: got %b required 10", rec_pair[0]);
        end
        w = rec_word(0);
        n_tests++;
        if (w !== 32'h9555_6AAA) begin
            n_fail++;
            $display("FAIL single_frame: got %h required 95556aaa", w);
        end
        fs_cnt = 0;
        for (int i = 0; i < 17; i++) if (rec_fs[i] === 1'b1) fs_cnt++;
        n_tests++;
        if (rec_fs[0] !== 1'b1 || fs_cnt != 1) begin
            n_fail++;
            $display("FAIL single_frame_start: fs[0]=%b count=%0d required 1 and 1", rec_fs[0], fs_cnt);
        end
        n_tests++;
        if (count_pulls(0, 16) != 0) begin
            n_fail++;
            $display("FAIL single_extra_pull: got %0d pulls required 0", count_pulls(0, 16));
        end
        n_tests++;
        if ({rec_busy[15], rec_busy[16], rec_ur[16], o_busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_to_idle: busy15/busy16/ur/busy got %b required 1000",
                     {rec_busy[15], rec_busy[16], rec_ur[16], o_busy});
        end
    endtask

    task automatic test_ignored_bits();
        logic [31:0] w;
        do_reset();
        push(32'hD555_EAAA);
        start_stream();
        for (int i = 0; i < 17; i++) begin
            if (i == 10) i_tx_en = 1'b0;
            step();
        end
        w = rec_word(0);
        n_tests++;
        if (w !== 32'h9555_6AAA) begin
            n_fail++;
            $display("FAIL ignored_bits: got %h required 95556aaa", w);
        end
        n_tests++;
        if (rec_busy[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_bits_idle: busy got %b required 0", rec_busy[16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words [0:3];
        logic [31:0] w;
        int bad_pull;
        int bad_fs;
        int busy_cnt;
        exp_words[0] = 32'h8000_4000;
        exp_words[1] = 32'hBFFF_7FFF;
        exp_words[2] = 32'h9234_5678;
        exp_words[3] = 32'hABCD_6F01;
        do_reset();
        push(32'h0000_0000);
        push(32'hFFFF_FFFF);
        push(32'h1234_5678);
        push(32'hABCD_EF01);
        start_stream();
        for (int i = 0; i < 65; i++) begin
            if (i == 58) i_tx_en = 1'b0;
            step();
        end
        for (int f = 0; f < 4; f++) begin
            w = rec_word(f * 16);
            n_tests++;
            if (w !== exp_words[f]) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h required %h", f, w, exp_words[f]);
            end
        end
        bad_pull = 0;
        bad_fs   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 65; i++) begin
            if (rec_pull[i] !== ((i == 13) || (i == 29) || (i == 45))) bad_pull++;
            if (rec_fs[i] !== ((i % 16 == 0) && (i < 64))) bad_fs++;
            if (rec_busy[i] === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (bad_pull != 0) begin
            n_fail++;
            $display("FAIL b2b_pull_timing: got %0d misplaced pull cycles required 0", bad_pull);
        end
        n_tests++;
        if (bad_fs != 0) begin
            n_fail++;
            $display("FAIL b2b_frame_start: got %0d misplaced frame_start cycles required 0", bad_fs);
        end
        n_tests++;
        if (busy_cnt != 64 || rec_busy[64] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d busy cycles (last=%b) required 64 (last=0)", busy_cnt, rec_busy[64]);
        end
        n_tests++;
        if (rec_ur[64] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_underrun: got %b required 0", rec_ur[64]);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] w;
        do_reset();
        push(32'h1555_2AAA);
        push(32'h1234_5678);
        start_stream();
        for (int i = 0; i < 81; i++) begin
            if (i == 47) i_clear_underrun = 1'b1;
            if (i == 48) i_clear_underrun = 1'b0;
            if (i == 56) push(32'hABCD_EF01);
            if (i == 66) i_clear_underrun = 1'b1;
            if (i == 67) i_clear_underrun = 1'b0;
            if (i == 70) i_tx_en = 1'b0;
            step();
        end
        w = rec_word(0);
        n_tests++;
        if (w !== 32'h9555_6AAA) begin
            n_fail++;
            $display("FAIL ur_frame1: got %h required 95556aaa", w);
        end
        w = rec_word(16);
        n_tests++;
        if (w !== 32'h9234_5678) begin
            n_fail++;
            $display("FAIL ur_frame2: got %h required 92345678", w);
        end
        w = rec_word(32);
        n_tests++;
        if (w !== 32'h0 || rec_fs[32] !== 1'b1 || rec_busy[40] !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_idle_frame3: word %h fs %b busy %b required 00000000 1 1", w, rec_fs[32], rec_busy[40]);
        end
        w = rec_word(48);
        n_tests++;
        if (w !== 32'h0) begin
            n_fail++;
            $display("FAIL ur_idle_frame4: got %h required 00000000", w);
        end
        n_tests++;
        if ({rec_ur[31], rec_ur[32], rec_ur[47]} !== 3'b011) begin
            n_fail++;
            $display("FAIL ur_set: ur31/32/47 got %b required 011", {rec_ur[31], rec_ur[32], rec_ur[47]});
        end
        n_tests++;
        if (rec_ur[48] !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_set_priority: got %b required 1", rec_ur[48]);
        end
        n_tests++;
        if (rec_pull[61] !== 1'b1 || count_pulls(0, 80) != 2) begin
            n_fail++;
            $display("FAIL ur_refill_pull: pull61 %b count %0d required 1 and 2", rec_pull[61], count_pulls(0, 80));
        end
        w = rec_word(64);
        n_tests++;
        if (w !== 32'hABCD_6F01 || rec_fs[64] !== 1'b1) begin
            n_fail++;
            $display("FAIL ur_resume: word %h fs %b required abcd6f01 1", w, rec_fs[64]);
        end
        n_tests++;
        if ({rec_ur[64], rec_ur[66], rec_ur[67], rec_ur[79]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL ur_clear: ur64/66/67/79 got %b required 1100",
                     {rec_ur[64], rec_ur[66], rec_ur[67], rec_ur[79]});
        end
        n_tests++;
        if ({rec_busy[79], rec_busy[80], rec_ur[80]} !== 3'b100) begin
            n_fail++;
            $display("FAIL ur_final_idle: busy79/busy80/ur80 got %b required 100",
                     {rec_busy[79], rec_busy[80], rec_ur[80]});
        end
    endtask

    task automatic test_late_disable();
        logic [31:0] w;
        int ur_cnt;
        do_reset();
        push(32'h1555_2AAA);
        push(32'h1234_5678);
        start_stream();
        for (int i = 0; i < 36; i++) begin
            if (i == 14) i_tx_en = 1'b0;
            step();
        end
        w = rec_word(0);
        n_tests++;
        if (w !== 32'h9555_6AAA) begin
            n_fail++;
            $display("FAIL late_frame1: got %h required 95556aaa", w);
        end
        w = rec_word(16);
        n_tests++;
        if (w !== 32'h9234_5678) begin
            n_fail++;
            $display("FAIL late_pulled_frame: got %h required 92345678", w);
        end
        n_tests++;
        if (rec_pull[13] !== 1'b1 || count_pulls(0, 35) != 1) begin
            n_fail++;
            $display("FAIL late_pulls: pull13 %b count %0d required 1 and 1", rec_pull[13], count_pulls(0, 35));
        end
        n_tests++;
        if ({rec_busy[31], rec_busy[32], rec_busy[35]} !== 3'b100) begin
            n_fail++;
            $display("FAIL late_idle: busy31/32/35 got %b required 100", {rec_busy[31], rec_busy[32], rec_busy[35]});
        end
        ur_cnt = 0;
        for (int i = 0; i < 36; i++) if (rec_ur[i] !== 1'b0) ur_cnt++;
        n_tests++;
        if (ur_cnt != 0) begin
            n_fail++;
            $display("FAIL late_underrun: got %0d cycles with underrun required 0", ur_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        do_reset();
        push(32'h1555_2AAA);
        push(32'h1234_5678);
        start_stream();
        for (int i = 0; i < 7; i++) tick();
        n_tests++;
        if ({o_busy, o_tx_bit_rise, o_tx_bit_fall} !== 3'b101) begin
            n_fail++;
            $display("FAIL async_pre: busy/rise/fall got %b required 101", {o_busy, o_tx_bit_rise, o_tx_bit_fall});
        end
        #3;
        i_reset = 1'b1;
        #1;
        n_tests++;
        if ({o_fifo_pull, o_tx_bit_rise, o_tx_bit_fall, o_frame_start, o_busy, o_underrun} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_immediate: got %b required 000000",
                     {o_fifo_pull, o_tx_bit_rise, o_tx_bit_fall, o_frame_start, o_busy, o_underrun});
        end
        tick();
        i_reset = 1'b0;
        n_tests++;
        if ({o_fifo_pull, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL async_release: pull/busy got %b required 00", {o_fifo_pull, o_busy});
        end
        tick();
        n_tests++;
        if (o_fifo_pull !== 1'b1) begin
            n_fail++;
            $display("FAIL async_restart_pull: got %b required 1", o_fifo_pull);
        end
        tick();
        tick();
        n_tests++;
        if ({o_frame_start, o_tx_bit_rise, o_tx_bit_fall} !== 3'b110) begin
            n_fail++;
            $display("FAIL async_restart_latency: fs/rise/fall got %b required 110",
                     {o_frame_start, o_tx_bit_rise, o_tx_bit_fall});
        end
        i_tx_en = 1'b0;
        rec_n = 0;
        for (int i = 0; i < 17; i++) step();
        w = rec_word(0);
        n_tests++;
        if (w !== 32'h9234_5678 || rec_busy[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_restart_frame: word %h busy %b required 92345678 0", w, rec_busy[16]);
        end
    endtask

    initial begin
        i_reset          = 1'b1;
        i_tx_en          = 1'b0;
        i_fifo_empty     = 1'b1;
        i_fifo_data      = 32'h0;
        i_clear_underrun = 1'b0;
        rec_n            = 0;
        @(posedge i_ddr_clk);
        #1;
        test_reset();
        test_single_frame();
        test_ignored_bits();
        test_back_to_back();
        test_underrun();
        test_late_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
